// File: rtl/a_s_sched.sv
// a_s_sched: two-requester round-robin scheduler around one shared 8-bit
// add/sub slice. Each 16-bit operation takes a low-byte and a high-byte pass
// (LO, HI), then one DONE cycle carrying the requester's ack.
module a_s_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        s0,
    input  logic        req1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic        s1,
    output logic        ack0,
    output logic        ack1,
    output logic        busy,
    output logic        gnt,
    output logic [15:0] sum16,
    output logic        cout16,
    output logic        ovf16
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [15:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        s_q, s_d;
    logic [7:0]  lo_q, lo_d;
    logic        c_lo_q, c_lo_d;

    logic        win;
    logic [7:0]  slice_x;
    logic [7:0]  slice_y;
    logic        slice_cin;
    logic [8:0]  slice_r;
    logic        y_sign;

    // Round-robin pick: a lone request wins; on contention the one not granted last wins.
    assign win = (req0 && req1) ? ~last_q : req1;

    // The single shared 8-bit slice, steered onto the low or high byte by state.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and gives every output a
        // default first, so no path leaves a signal unassigned (no latch).
        slice_x   = a_q[7:0];
        slice_y   = b_q[7:0];
        slice_cin = s_q;
        if (state_q == HI) begin
            slice_x   = a_q[15:8];
            slice_y   = b_q[15:8];
            slice_cin = c_lo_q;
        end
        slice_r = {1'b0, slice_x} + {1'b0, slice_y ^ {8{s_q}}} + {8'd0, slice_cin};
        y_sign  = b_q[15] ^ s_q;
    end

    // Next-state and datapath update for the IDLE -> LO -> HI -> DONE sequence.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        lo_d    = lo_q;
        c_lo_d  = c_lo_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = win;
                    last_d  = win;
                    a_d     = win ? a1 : a0;
                    b_d     = win ? b1 : b0;
                    s_d     = win ? s1 : s0;
                    state_d = LO;
                end
            end
            LO: begin
                lo_d    = slice_r[7:0];
                c_lo_d  = slice_r[8];
                state_d = HI;
            end
            HI: begin
                sum_d   = {slice_r[7:0], lo_q};
                cout_d  = slice_r[8];
                ovf_d   = (a_q[15] == y_sign) && (slice_r[7] != a_q[15]);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and visible result registers; reset wins over any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            sum_q   <= 16'd0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand and low-byte staging registers.
    always_ff @(posedge clk) begin
        // NOTE: these are left unreset on purpose: they are always written in
        // IDLE/LO before being read, so a reset would only cost logic.
        a_q    <= a_d;
        b_q    <= b_d;
        s_q    <= s_d;
        lo_q   <= lo_d;
        c_lo_q <= c_lo_d;
    end

    assign busy   = (state_q != IDLE);
    assign ack0   = (state_q == DONE) && !gnt_q;
    assign ack1   = (state_q == DONE) && gnt_q;
    assign gnt    = gnt_q;
    assign sum16  = sum_q;
    assign cout16 = cout_q;
    assign ovf16  = ovf_q;

endmodule

// File: tb/tb_a_s_sched.sv
// tb_a_s_sched: table-driven vectors for the arithmetic, plus hand-written
// sequences for round-robin contention and reset mid-operation.
module tb_a_s_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        s0, s1;
    logic        ack0, ack1, busy, gnt;
    logic [15:0] sum16;
    logic        cout16, ovf16;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    a_s_sched dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .a0     (a0),
        .b0     (b0),
        .s0     (s0),
        .req1   (req1),
        .a1     (a1),
        .b1     (b1),
        .s1     (s1),
        .ack0   (ack0),
        .ack1   (ack1),
        .busy   (busy),
        .gnt    (gnt),
        .sum16  (sum16),
        .cout16 (cout16),
        .ovf16  (ovf16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic scramble;
        a0 = 16'($urandom);
        b0 = 16'($urandom);
        s0 = 1'($urandom);
        a1 = 16'($urandom);
        b1 = 16'($urandom);
        s1 = 1'($urandom);
    endtask

    // One request from idle; operands are garbled every cycle after acceptance.
    task automatic run_op(input vec_t v);
        int cyc;
        if (v.id == 1'b0) begin
            req0 = 1'b1; a0 = v.a; b0 = v.b; s0 = v.s;
        end else begin
            req1 = 1'b1; a1 = v.a; b1 = v.b; s1 = v.s;
        end
        tick;
        cyc = 1;
        check("busy_after_accept", busy, 1);
        check("gnt_after_accept", gnt, v.id);
        req0 = 1'b0;
        req1 = 1'b0;
        scramble();
        while (!(ack0 || ack1) && cyc < 10) begin
            tick;
            cyc++;
            scramble();
        end
        check("ack_latency", cyc, 3);
        check("ack_select", {ack1, ack0}, v.id ? 2'b10 : 2'b01);
        check("busy_in_done", busy, 1);
        check("sum16", sum16, v.sum);
        check("cout16", cout16, v.cout);
        check("ovf16", ovf16, v.ovf);
        tick;
        check("idle_busy", busy, 0);
        check("idle_acks", {ack1, ack0}, 2'b00);
        check("sum16_held", sum16, v.sum);
        check("gnt_held", gnt, v.id);
    endtask

    initial begin
        // {id, a, b, s, sum, cout, ovf}
        vecs[0] = '{1'b0, 16'h0F0F, 16'h0C0C, 1'b0, 16'h1B1B, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h5656, 16'h3F3F, 1'b1, 16'h1717, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; s0 = 1'b0;
        a1 = '0; b1 = '0; s1 = 1'b0;
        tick;
        tick;
        check("rst_busy", busy, 0);
        check("rst_acks", {ack1, ack0}, 2'b00);
        check("rst_gnt", gnt, 0);
        check("rst_result", {15'd0, ovf16, cout16, sum16}, 32'd0);
        rst = 1'b0;
        tick;
        check("idle_no_req", busy, 0);

        for (int i = 0; i < 6; i++) run_op(vecs[i]);

        // Both requesters held high through reset: grants 0,1,0,1 every 4 cycles.
        rst = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            tick;
            check("rr_ack0", ack0, (t == 3) || (t == 11));
            check("rr_ack1", ack1, (t == 7) || (t == 15));
            check("rr_busy", busy, (t % 4) != 0);
            if ((t % 4) == 1) check("rr_gnt", gnt, ((t - 1) / 4) % 2);
        end
        req0 = 1'b0;
        req1 = 1'b0;

        // Reset landing in HI discards the operation; held req0 is re-accepted.
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h0001; s0 = 1'b0;
        tick;
        tick;
        check("mid_busy_hi", busy, 1);
        rst = 1'b1;
        tick;
        check("mid_rst_acks", {ack1, ack0}, 2'b00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_result", {15'd0, ovf16, cout16, sum16}, 32'd0);
        tick;
        check("mid_rst_hold_acks", {ack1, ack0}, 2'b00);
        rst = 1'b0;
        tick;
        check("reaccept_busy", busy, 1);
        check("reaccept_gnt", gnt, 0);
        req0 = 1'b0;
        tick;
        tick;
        check("reaccept_ack0", {ack1, ack0}, 2'b01);
        check("reaccept_sum", sum16, 16'h1235);
        tick;
        check("reaccept_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
